plic_claim_ctrl: RTL and testbench
==================================

Name: plic_claim_ctrl

Overview:
- Per-context claim/complete controller for the PLIC.
- Sequentially scans gateway pending bits and selects the highest-priority enabled source above threshold. Serves claim reads and tracks in-service sources.
- Drives the one-cycle complete_id broadcast back to the gateways and the context's external IRQ.
- Sits inside plic_core between the register file (priority/enable/threshold) and the gateways.

Parameters:
- NUM_SOURCES_P, default plic_pkg::NUM_SOURCES (31): number of interrupt sources; IDs 1..NUM_SOURCES_P; ID 0 means "none".
- PRIO_WIDTH_P, default plic_pkg::PRIO_WIDTH (3): priority/threshold width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pending_i  in  [NUM_SOURCES_P:1]  gateway pending bits.
- enable_i  in  [NUM_SOURCES_P:1]  context enable bits.
- prio_i  in  NUM_SOURCES_P x PRIO_WIDTH_P, packed, source i at slice i-1: source priorities.
- threshold_i  in  PRIO_WIDTH_P  context threshold.
- claim_i  in  1  single-cycle claim-register read strobe.
- complete_i  in  1  single-cycle complete-register write strobe.
- complete_wid_i  in  SOURCE_ID_WIDTH  ID written on complete.
- claim_id_o  out  SOURCE_ID_WIDTH  ID returned for the claim, valid the cycle after claim_i.
- complete_id_o  out  SOURCE_ID_WIDTH  one-cycle pulse of the completed ID to the gateways; 0 otherwise.
- in_service_o  out  [NUM_SOURCES_P:1]  claimed-not-completed mask.
- irq_o  out  1  external interrupt request for this context.

Behaviour:
- Reset (async, rst_n=0): every output is 0. Scan index=1, running best cleared, committed best_id/best_prio=0, FSM=SCAN.
- Eligibility of source i: pending_i[i] & enable_i[i] & ~in_service[i] & (prio_i[i] > threshold_i). Priority 0 is therefore never eligible.
- FSM states: SCAN and COMMIT.
- SCAN: evaluate one source per cycle at idx.
  - If the source is eligible and its prio > run_prio (strictly greater), load run_id=idx and run_prio=prio.
  - Ties keep the lower ID.
  - At idx==NUM_SOURCES_P go to COMMIT; otherwise idx+1.
- COMMIT (1 cycle): best_id<=run_id, best_prio<=run_prio. Clear run_*, set idx=1, return to SCAN.
- Full sweep latency is NUM_SOURCES_P+1 cycles. irq_o and best_id reflect a source change within 2*(NUM_SOURCES_P+1) cycles.
- irq_o is registered: 1 when the committed best_id!=0 and that source is still eligible (checked combinationally on the committed ID). It drops the cycle after the source becomes ineligible.
- Claim (claim_i=1):
  - Next cycle, claim_id_o = best_id if still eligible, else 0.
  - If nonzero, set in_service[best_id].
  - Clear best_id/best_prio and the run_* registers, and restart the scan at idx=1 in SCAN (abort any partial sweep).
  - claim_id_o holds its value until the next claim.
- Complete (complete_i=1):
  - If 1 <= complete_wid_i <= NUM_SOURCES_P and in_service[complete_wid_i]=1: clear that bit and drive complete_id_o=complete_wid_i for exactly the next cycle.
  - Otherwise the complete is ignored: no bit change, complete_id_o stays 0.
- Simultaneous claim and complete: both take effect in the same cycle. A complete of ID X and a claim granting Y update in_service together. X==Y cannot occur, because an in-service source is ineligible.
- Out-of-range IDs (0 or >NUM_SOURCES_P) never index arrays.
- Reset mid-sweep: all state is discarded immediately; no complete pulse is emitted.
- Width rule: SOURCE_ID_WIDTH = $clog2(NUM_SOURCES_P+1). idx never exceeds NUM_SOURCES_P.

Decomposition:
- plic_pkg holds NUM_SOURCES, PRIO_WIDTH, SOURCE_ID_WIDTH, the scan FSM enum (SCAN/COMMIT) and a prio_t typedef.
- No sub-module required. The eligibility/compare step may be a function in plic_pkg.

Test Plan:
- Reset with pending_i all 1 -> all outputs 0 during reset; irq_o=1 within 2*(N+1) cycles of release, given srcs 3 (prio 5) and 7 (prio 2) enabled and threshold 1.
- Srcs 3 and 7 both at prio 4, threshold 0 -> claim returns 3 (tie goes to lower ID); second claim after a sweep returns 7; in_service_o=bit3|bit7.
- Src 5 at prio 2, threshold 2 -> irq_o stays 0 and claim returns 0. Lower threshold to 1 -> irq_o=1 within 2*(N+1) cycles.
- Claim returns 5, then complete_wid_i=5 -> complete_id_o=5 for exactly one cycle and in_service[5] clears. Repeat complete of 5 -> complete_id_o stays 0.
- Same cycle: claim grants 9 and complete of 5 -> in_service has bit9 set and bit5 cleared; complete_id_o=5 next cycle.
- Clear enable_i[9] after commit but before claim -> claim returns 0 and irq_o falls next cycle. Assert rst_n=0 mid-sweep -> outputs 0 asynchronously.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared PLIC constants and types.
// Sizes the claim/complete controller and names its scan states.
package plic_pkg;

    localparam int NUM_SOURCES     = 31;
    localparam int PRIO_WIDTH      = 3;
    localparam int SOURCE_ID_WIDTH = $clog2(NUM_SOURCES + 1);

    typedef logic [PRIO_WIDTH-1:0] prio_t;

    typedef enum logic [0:0] {
        SCAN   = 1'b0,
        COMMIT = 1'b1
    } scan_state_e;

endpackage

// File: rtl/plic_claim_ctrl.sv
// Per-context PLIC claim/complete controller.
// Sequential priority scan, claim service and in-service tracking.
module plic_claim_ctrl
    import plic_pkg::*;
#(
    parameter int  NUM_SOURCES_P = NUM_SOURCES,
    parameter int  PRIO_WIDTH_P  = PRIO_WIDTH,
    localparam int IDW           = $clog2(NUM_SOURCES_P + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_SOURCES_P:1]                pending_i,
    input  logic [NUM_SOURCES_P:1]                enable_i,
    input  logic [NUM_SOURCES_P*PRIO_WIDTH_P-1:0] prio_i,
    input  logic [PRIO_WIDTH_P-1:0]               threshold_i,
    input  logic                                  claim_i,
    input  logic                                  complete_i,
    input  logic [IDW-1:0]                        complete_wid_i,
    output logic [IDW-1:0]                        claim_id_o,
    output logic [IDW-1:0]                        complete_id_o,
    output logic [NUM_SOURCES_P:1]                in_service_o,
    output logic                                  irq_o
);

    logic [IDW-1:0]          r_idx;
    logic [IDW-1:0]          r_run_id;
    logic [IDW-1:0]          r_best_id;
    logic [IDW-1:0]          r_claim_id;
    logic [IDW-1:0]          r_cpl_id;
    logic [PRIO_WIDTH_P-1:0] r_run_prio;
    logic [PRIO_WIDTH_P-1:0] r_best_prio;
    scan_state_e             r_state;
    logic                    r_irq;
    logic [NUM_SOURCES_P:1]  r_in_service;

    logic [NUM_SOURCES_P:1]  w_elig;
    logic [NUM_SOURCES_P:1]  w_idx_oh;
    logic [NUM_SOURCES_P:1]  w_best_oh;
    logic [NUM_SOURCES_P:1]  w_cpl_hit;
    logic [NUM_SOURCES_P:1]  w_claim_set;
    logic [PRIO_WIDTH_P-1:0] w_idx_prio;
    logic                    w_idx_elig;
    logic                    w_best_ok;

    // One-hot decodes keep out-of-range IDs from ever indexing a vector.
    always_comb begin
        w_idx_prio = '0;
        for (int i = 1; i <= NUM_SOURCES_P; i++) begin
            w_elig[i] = pending_i[i] & enable_i[i] & ~r_in_service[i]
                      & (prio_i[(i-1)*PRIO_WIDTH_P +: PRIO_WIDTH_P]
                         > threshold_i);
            w_idx_oh[i]  = (r_idx == IDW'(i));
            w_best_oh[i] = (r_best_id == IDW'(i));
            w_cpl_hit[i] = complete_i & r_in_service[i]
                         & (complete_wid_i == IDW'(i));
            w_idx_prio = w_idx_prio
                       | (prio_i[(i-1)*PRIO_WIDTH_P +: PRIO_WIDTH_P]
                          & {PRIO_WIDTH_P{w_idx_oh[i]}});
        end
        w_idx_elig  = |(w_idx_oh & w_elig);
        w_best_ok   = (r_best_prio != '0) & (|(w_best_oh & w_elig));
        w_claim_set = (claim_i & w_best_ok) ? w_best_oh : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= IDW'(1);
            r_run_id     <= '0;
            r_run_prio   <= '0;
            r_best_id    <= '0;
            r_best_prio  <= '0;
            r_claim_id   <= '0;
            r_cpl_id     <= '0;
            r_state      <= SCAN;
            r_irq        <= 1'b0;
            r_in_service <= '0;
        end else begin
            r_in_service <= (r_in_service & ~w_cpl_hit) | w_claim_set;
            r_cpl_id     <= (|w_cpl_hit) ? complete_wid_i : '0;
            r_irq        <= ~claim_i & w_best_ok;
            if (claim_i) begin
                r_claim_id  <= w_best_ok ? r_best_id : '0;
                r_best_id   <= '0;
                r_best_prio <= '0;
                r_run_id    <= '0;
                r_run_prio  <= '0;
                r_idx       <= IDW'(1);
                r_state     <= SCAN;
            end else begin
                unique case (r_state)
                    SCAN: begin
                        // Strict compare: ties keep the lower ID.
                        if (w_idx_elig && (w_idx_prio > r_run_prio)) begin
                            r_run_id   <= r_idx;
                            r_run_prio <= w_idx_prio;
                        end
                        if (r_idx == IDW'(NUM_SOURCES_P)) begin
                            r_state <= COMMIT;
                        end else begin
                            r_idx <= r_idx + IDW'(1);
                        end
                    end
                    COMMIT: begin
                        r_best_id   <= r_run_id;
                        r_best_prio <= r_run_prio;
                        r_run_id    <= '0;
                        r_run_prio  <= '0;
                        r_idx       <= IDW'(1);
                        r_state     <= SCAN;
                    end
                endcase
            end
        end
    end

    assign claim_id_o    = r_claim_id;
    assign complete_id_o = r_cpl_id;
    assign in_service_o  = r_in_service;
    assign irq_o         = r_irq;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Directed bench for plic_claim_ctrl.
// Hand-computed claim, complete, irq and reset expectations.
module tb_plic_claim_ctrl;

    localparam int N   = 31;
    localparam int PW  = 3;
    localparam int IDW = 5;
    localparam int SWEEP = 2 * (N + 1) + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N:1]      pending_i;
    logic [N:1]      enable_i;
    logic [N*PW-1:0] prio_i;
    logic [PW-1:0]   threshold_i;
    logic            claim_i;
    logic            complete_i;
    logic [IDW-1:0]  complete_wid_i;
    logic [IDW-1:0]  claim_id_o;
    logic [IDW-1:0]  complete_id_o;
    logic [N:1]      in_service_o;
    logic            irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    plic_claim_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pending_i      (pending_i),
        .enable_i       (enable_i),
        .prio_i         (prio_i),
        .threshold_i    (threshold_i),
        .claim_i        (claim_i),
        .complete_i     (complete_i),
        .complete_wid_i (complete_wid_i),
        .claim_id_o     (claim_id_o),
        .complete_id_o  (complete_id_o),
        .in_service_o   (in_service_o),
        .irq_o          (irq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N:1] src(input int s);
        logic [N:1] m;
        m = '0;
        m[s] = 1'b1;
        return m;
    endfunction

    task automatic set_prio(input int s, input int p);
        prio_i[(s-1)*PW +: PW] = PW'(p);
    endtask

    task automatic do_claim(input string tag, input int exp);
        claim_i = 1'b1;
        tick();
        claim_i = 1'b0;
        chk(tag, 32'(claim_id_o), 32'(exp));
    endtask

    task automatic do_complete(input string tag, input int id,
                               input int exp);
        complete_i     = 1'b1;
        complete_wid_i = IDW'(id);
        tick();
        complete_i     = 1'b0;
        chk(tag, 32'(complete_id_o), 32'(exp));
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (irq_o !== 1'b1 && n < SWEEP) begin
            tick();
            n++;
        end
        chk(tag, 32'(irq_o), 32'd1);
    endtask

    task automatic wait_sweep();
        repeat (SWEEP) tick();
    endtask

    initial begin
        pending_i      = '1;
        enable_i       = src(3) | src(7);
        prio_i         = '0;
        threshold_i    = PW'(1);
        claim_i        = 1'b0;
        complete_i     = 1'b0;
        complete_wid_i = '0;
        set_prio(3, 5);
        set_prio(7, 2);

        #1 rst_n = 1'b0;
        #2;
        chk("rst_claim_id", 32'(claim_id_o), 0);
        chk("rst_cpl_id", 32'(complete_id_o), 0);
        chk("rst_in_svc", 32'(in_service_o), 0);
        chk("rst_irq", 32'(irq_o), 0);
        tick();
        rst_n = 1'b1;
        wait_irq("irq_after_rst");
        do_claim("claim_hi_prio", 3);
        chk("in_svc_3", 32'(in_service_o), 32'(src(3)));
        chk("irq_drop_claim", 32'(irq_o), 0);
        do_complete("cpl_3", 3, 3);
        chk("in_svc_clr3", 32'(in_service_o), 0);
        tick();
        chk("cpl_pulse_end", 32'(complete_id_o), 0);

        set_prio(3, 4);
        set_prio(7, 4);
        threshold_i = '0;
        wait_sweep();
        do_claim("tie_low_id", 3);
        wait_sweep();
        do_claim("tie_second", 7);
        chk("in_svc_3_7", 32'(in_service_o), 32'(src(3) | src(7)));
        do_complete("cpl_3b", 3, 3);
        do_complete("cpl_7", 7, 7);
        chk("in_svc_empty", 32'(in_service_o), 0);

        enable_i    = src(5);
        set_prio(5, 2);
        threshold_i = PW'(2);
        wait_sweep();
        chk("irq_at_thr", 32'(irq_o), 0);
        do_claim("claim_at_thr", 0);
        threshold_i = PW'(1);
        wait_irq("irq_thr_low");
        do_claim("claim_5", 5);
        do_complete("cpl_5", 5, 5);
        chk("in_svc_clr5", 32'(in_service_o), 0);
        tick();
        chk("cpl_5_once", 32'(complete_id_o), 0);
        do_complete("cpl_5_again", 5, 0);
        do_complete("cpl_id0", 0, 0);

        enable_i = src(5) | src(9);
        set_prio(5, 3);
        set_prio(9, 2);
        wait_sweep();
        do_claim("claim_5b", 5);
        wait_sweep();
        claim_i        = 1'b1;
        complete_i     = 1'b1;
        complete_wid_i = IDW'(5);
        tick();
        claim_i    = 1'b0;
        complete_i = 1'b0;
        chk("sim_claim", 32'(claim_id_o), 9);
        chk("sim_cpl", 32'(complete_id_o), 5);
        chk("sim_in_svc", 32'(in_service_o), 32'(src(9)));
        do_complete("cpl_9", 9, 9);

        enable_i = src(1) | src(31);
        set_prio(1, 1);
        set_prio(31, 7);
        threshold_i = '0;
        wait_sweep();
        do_claim("claim_31", 31);
        chk("in_svc_31", 32'(in_service_o), 32'(src(31)));
        do_complete("cpl_31", 31, 31);

        enable_i = src(9);
        threshold_i = PW'(1);
        wait_sweep();
        chk("irq_9", 32'(irq_o), 1);
        enable_i = '0;
        tick();
        chk("irq_fall", 32'(irq_o), 0);
        do_claim("claim_disabled", 0);
        chk("in_svc_none", 32'(in_service_o), 0);

        enable_i = src(9);
        wait_irq("irq_9b");
        do_claim("claim_9b", 9);
        repeat (5) tick();
        complete_i     = 1'b1;
        complete_wid_i = IDW'(9);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_svc", 32'(in_service_o), 0);
        chk("mid_rst_claim", 32'(claim_id_o), 0);
        chk("mid_rst_irq", 32'(irq_o), 0);
        tick();
        chk("mid_rst_cpl", 32'(complete_id_o), 0);
        complete_i = 1'b0;
        rst_n      = 1'b1;
        tick();
        chk("post_rst_cpl", 32'(complete_id_o), 0);
        chk("post_rst_svc", 32'(in_service_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
